// File: rtl/rf_writeback_queue_if.sv
// Writeback queue bus: ALU/load producer handshakes,
// register-file write port and decode hazard lookup.
interface rf_writeback_queue_if #(
  parameter int DW = 32
);
  logic          alu_valid;
  logic          alu_ready;
  logic [4:0]    alu_rd;
  logic [DW-1:0] alu_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [4:0]    mem_rd;
  logic [DW-1:0] mem_data;
  logic [4:0]    rf_rd;
  logic [DW-1:0] rf_wd;
  logic          rf_wr;
  logic [4:0]    chk_rs1;
  logic [4:0]    chk_rs2;
  logic          hit1;
  logic          hit2;
  logic [DW-1:0] fwd1;
  logic [DW-1:0] fwd2;
  logic          empty;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mem_valid, mem_rd, mem_data,
    output chk_rs1, chk_rs2,
    input  alu_ready, mem_ready,
    input  rf_rd, rf_wd, rf_wr,
    input  hit1, hit2, fwd1, fwd2, empty
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mem_valid, mem_rd, mem_data,
    input  chk_rs1, chk_rs2,
    output alu_ready, mem_ready,
    output rf_rd, rf_wd, rf_wr,
    output hit1, hit2, fwd1, fwd2, empty
  );
endinterface

// File: rtl/rf_writeback_queue.sv
// In-order writeback queue feeding the register file write port.
// Define WBQ_FWD_EN to build the pending-data forwarding mux.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input logic clk,
  input logic rst_n,
  rf_writeback_queue_if.slave bus
);

  typedef struct packed {
    logic [4:0]    rd;
    logic [DW-1:0] data;
  } wb_t;

  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] FREE1 = (AW+1)'(DEPTH - 1);
  localparam logic [AW:0] FREE2 = (AW+1)'(DEPTH - 2);

  wb_t           q [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [DEPTH-1:0] vld_nxt;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] slot_b;
  logic [AW:0]   count;
  logic [AW:0]   count_nxt;

  logic          out_wr;
  logic [4:0]    out_rd;
  logic [DW-1:0] out_wd;

  logic mem_rdy;
  logic alu_rdy;
  logic mem_push;
  logic alu_push;
  logic pop;

  // Ready looks only at the registered count, so a full
  // queue never accepts on the strength of a same-cycle pop.
  assign mem_rdy = (count != FULL);
  assign alu_rdy = (count <= FREE2) ||
                   ((count == FREE1) && !bus.mem_valid);

  assign mem_push = bus.mem_valid && mem_rdy &&
                    (bus.mem_rd != 5'd0);
  assign alu_push = bus.alu_valid && alu_rdy &&
                    (bus.alu_rd != 5'd0);
  assign pop      = (count != '0);

  // Load entry is older, so it takes the first free slot.
  assign slot_b = wr_ptr + AW'(mem_push);

  assign count_nxt = count
                   + (AW+1)'(mem_push)
                   + (AW+1)'(alu_push)
                   - (AW+1)'(pop);

  always_comb begin
    vld_nxt = vld;
    if (pop)      vld_nxt[rd_ptr] = 1'b0;
    if (mem_push) vld_nxt[wr_ptr] = 1'b1;
    if (alu_push) vld_nxt[slot_b] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      out_wr <= 1'b0;
      out_rd <= 5'd0;
      out_wd <= '0;
    end else begin
      rd_ptr <= rd_ptr + AW'(pop);
      wr_ptr <= wr_ptr + AW'(mem_push) + AW'(alu_push);
      count  <= count_nxt;
      vld    <= vld_nxt;
      out_wr <= pop;
      if (pop) begin
        out_rd <= q[rd_ptr].rd;
        out_wd <= q[rd_ptr].data;
      end
    end
  end

  // Entry payload needs no reset; validity lives in vld.
  always_ff @(posedge clk) begin
    if (mem_push) q[wr_ptr] <= '{rd: bus.mem_rd, data: bus.mem_data};
    if (alu_push) q[slot_b] <= '{rd: bus.alu_rd, data: bus.alu_data};
  end

  logic [4:0]    chk [2];
  logic [1:0]    hit;
  logic [DW-1:0] dat [2];
  logic [AW-1:0] idx;

  assign chk[0] = bus.chk_rs1;
  assign chk[1] = bus.chk_rs2;

  // Scan oldest to youngest so the last match wins.
  always_comb begin
    hit = '0;
    idx = '0;
    for (int p = 0; p < 2; p++) begin
      dat[p] = '0;
      if (out_wr && (out_rd == chk[p])) begin
        hit[p] = 1'b1;
`ifdef WBQ_FWD_EN
        dat[p] = out_wd;
`endif
      end
      for (int k = 0; k < DEPTH; k++) begin
        idx = rd_ptr + AW'(k);
        if (vld[idx] && (q[idx].rd == chk[p])) begin
          hit[p] = 1'b1;
`ifdef WBQ_FWD_EN
          dat[p] = q[idx].data;
`endif
        end
      end
      if (chk[p] == 5'd0) begin
        hit[p] = 1'b0;
        dat[p] = '0;
      end
    end
  end

  assign bus.alu_ready = alu_rdy;
  assign bus.mem_ready = mem_rdy;
  assign bus.rf_wr     = out_wr;
  assign bus.rf_rd     = out_rd;
  assign bus.rf_wd     = out_wd;
  assign bus.hit1      = hit[0];
  assign bus.hit2      = hit[1];
`ifdef WBQ_FWD_EN
  assign bus.fwd1      = dat[0];
  assign bus.fwd2      = dat[1];
`else
  assign bus.fwd1      = '0;
  assign bus.fwd2      = '0;
`endif
  assign bus.empty     = (count == '0) && !out_wr;

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench for rf_writeback_queue: ordering,
// backpressure, x0 drop, lookup and mid-run reset.
module tb_rf_writeback_queue;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rf_writeback_queue_if #(.DW(32)) bus ();

  rf_writeback_queue #(
    .DEPTH(4),
    .AW(2),
    .DW(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

`ifdef WBQ_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  function automatic logic [31:0] fx(input logic [31:0] d);
    return FWD ? d : 32'h0;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in;
    bus.alu_valid = 1'b0;
    bus.mem_valid = 1'b0;
  endtask

  initial begin
    bus.alu_valid = 1'b0;
    bus.alu_rd    = 5'd0;
    bus.alu_data  = 32'h0;
    bus.mem_valid = 1'b0;
    bus.mem_rd    = 5'd0;
    bus.mem_data  = 32'h0;
    bus.chk_rs1   = 5'd5;
    bus.chk_rs2   = 5'd0;

    step;
    step;
    chk("rst_rf_wr", 32'(bus.rf_wr), 32'd0);
    chk("rst_rf_rd", 32'(bus.rf_rd), 32'd0);
    chk("rst_rf_wd", bus.rf_wd, 32'h0);
    chk("rst_empty", 32'(bus.empty), 32'd1);
    chk("rst_alu_rdy", 32'(bus.alu_ready), 32'd1);
    chk("rst_mem_rdy", 32'(bus.mem_ready), 32'd1);
    chk("rst_hit1", 32'(bus.hit1), 32'd0);
    rst_n = 1'b1;
    step;

    // single write
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd5;
    bus.alu_data  = 32'h12345678;
    chk("s_alu_rdy", 32'(bus.alu_ready), 32'd1);
    step;
    idle_in;
    chk("s_wr_n", 32'(bus.rf_wr), 32'd0);
    chk("s_empty_n", 32'(bus.empty), 32'd0);
    chk("s_hit_q", 32'(bus.hit1), 32'd1);
    chk("s_fwd_q", bus.fwd1, fx(32'h12345678));
    step;
    chk("s_wr", 32'(bus.rf_wr), 32'd1);
    chk("s_rd", 32'(bus.rf_rd), 32'd5);
    chk("s_wd", bus.rf_wd, 32'h12345678);
    chk("s_hit_out", 32'(bus.hit1), 32'd1);
    step;
    chk("s_wr_end", 32'(bus.rf_wr), 32'd0);
    chk("s_empty", 32'(bus.empty), 32'd1);
    chk("s_hit_end", 32'(bus.hit1), 32'd0);

    // dual push, mem older than alu
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd3;
    bus.mem_data  = 32'hAAAA0000;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd3;
    bus.alu_data  = 32'h0000BBBB;
    bus.chk_rs1   = 5'd3;
    chk("d_alu_rdy", 32'(bus.alu_ready), 32'd1);
    chk("d_mem_rdy", 32'(bus.mem_ready), 32'd1);
    step;
    idle_in;
    chk("d_hit1", 32'(bus.hit1), 32'd1);
    chk("d_fwd1", bus.fwd1, fx(32'h0000BBBB));
    step;
    chk("d_wr0", 32'(bus.rf_wr), 32'd1);
    chk("d_rd0", 32'(bus.rf_rd), 32'd3);
    chk("d_wd0", bus.rf_wd, 32'hAAAA0000);
    chk("d_fwd1b", bus.fwd1, fx(32'h0000BBBB));
    step;
    chk("d_wr1", 32'(bus.rf_wr), 32'd1);
    chk("d_rd1", 32'(bus.rf_rd), 32'd3);
    chk("d_wd1", bus.rf_wd, 32'h0000BBBB);
    chk("d_fwd1c", bus.fwd1, fx(32'h0000BBBB));
    step;
    chk("d_wr_end", 32'(bus.rf_wr), 32'd0);
    chk("d_empty", 32'(bus.empty), 32'd1);

    // fill path: 3 dual requests, alu held back once
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd10;
    bus.mem_data  = 32'hA0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd11;
    bus.alu_data  = 32'hB0;
    bus.chk_rs1   = 5'd0;
    step;
    bus.mem_rd    = 5'd12;
    bus.mem_data  = 32'hA1;
    bus.alu_rd    = 5'd13;
    bus.alu_data  = 32'hB1;
    chk("f_alu_rdy2", 32'(bus.alu_ready), 32'd1);
    step;
    chk("f_wr10", 32'(bus.rf_rd), 32'd10);
    bus.chk_rs2   = 5'd13;
    #1;
    chk("f_hit2", 32'(bus.hit2), 32'd1);
    chk("f_fwd2", bus.fwd2, fx(32'hB1));
    bus.mem_rd    = 5'd14;
    bus.mem_data  = 32'hA2;
    bus.alu_rd    = 5'd15;
    bus.alu_data  = 32'hB2;
    chk("f_alu_blk", 32'(bus.alu_ready), 32'd0);
    chk("f_mem_rdy", 32'(bus.mem_ready), 32'd1);
    step;
    chk("f_wr11", 32'(bus.rf_rd), 32'd11);
    bus.mem_valid = 1'b0;
    #1;
    chk("f_alu_rel", 32'(bus.alu_ready), 32'd1);
    step;
    idle_in;
    chk("f_wr12", 32'(bus.rf_rd), 32'd12);
    chk("f_wd12", bus.rf_wd, 32'hA1);
    chk("f_mem_rdy3", 32'(bus.mem_ready), 32'd1);
    step;
    chk("f_wr13", 32'(bus.rf_rd), 32'd13);
    chk("f_wd13", bus.rf_wd, 32'hB1);
    step;
    chk("f_wr14", 32'(bus.rf_rd), 32'd14);
    chk("f_wd14", bus.rf_wd, 32'hA2);
    step;
    chk("f_wr15", 32'(bus.rf_rd), 32'd15);
    chk("f_wd15", bus.rf_wd, 32'hB2);
    chk("f_wv15", 32'(bus.rf_wr), 32'd1);
    step;
    chk("f_wr_end", 32'(bus.rf_wr), 32'd0);
    chk("f_empty", 32'(bus.empty), 32'd1);
    bus.chk_rs2   = 5'd0;

    // x0 destination is accepted and dropped
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd0;
    bus.mem_data  = 32'hFFFFFFFF;
    chk("z_mem_rdy", 32'(bus.mem_ready), 32'd1);
    step;
    idle_in;
    chk("z_wr0", 32'(bus.rf_wr), 32'd0);
    chk("z_empty0", 32'(bus.empty), 32'd1);
    chk("z_hit1", 32'(bus.hit1), 32'd0);
    step;
    chk("z_wr1", 32'(bus.rf_wr), 32'd0);
    chk("z_empty1", 32'(bus.empty), 32'd1);

    // reset while writes are pending
    bus.mem_valid = 1'b1;
    bus.mem_rd    = 5'd20;
    bus.mem_data  = 32'hC0;
    bus.alu_valid = 1'b1;
    bus.alu_rd    = 5'd21;
    bus.alu_data  = 32'hC1;
    step;
    bus.mem_valid = 1'b0;
    bus.alu_rd    = 5'd22;
    bus.alu_data  = 32'hC2;
    step;
    idle_in;
    chk("r_wr_pre", 32'(bus.rf_wr), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("r_wr", 32'(bus.rf_wr), 32'd0);
    chk("r_empty", 32'(bus.empty), 32'd1);
    chk("r_alu_rdy", 32'(bus.alu_ready), 32'd1);
    chk("r_mem_rdy", 32'(bus.mem_ready), 32'd1);
    step;
    rst_n = 1'b1;
    step;
    chk("r_wr_a", 32'(bus.rf_wr), 32'd0);
    step;
    chk("r_wr_b", 32'(bus.rf_wr), 32'd0);
    chk("r_empty_b", 32'(bus.empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/rf_writeback_queue.md
Name: rf_writeback_queue

Overview:
- Write-side feeder for the 32x32 general register file.
- Accepts writeback requests from two producers, the ALU and the load unit, over valid/ready handshakes.
- Buffers them in a small in-order queue and drives the register file's single write port (rd, WD, RFwr) at one write per cycle.
- Gives the decode stage a pending-write lookup on rs1/rs2, so it can detect hazards against writes not yet committed.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- AW, 2, pointer width, log2(DEPTH).
- DW, 32, data width.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alu_valid  in  1  ALU writeback request.
- alu_ready  out  1  ALU request accepted this cycle.
- alu_rd  in  5  ALU destination index.
- alu_data  in  DW  ALU result.
- mem_valid  in  1  load writeback request.
- mem_ready  out  1  load request accepted this cycle.
- mem_rd  in  5  load destination index.
- mem_data  in  DW  load data.
- rf_rd  out  5  to register file rd.
- rf_wd  out  DW  to register file WD.
- rf_wr  out  1  to register file RFwr.
- chk_rs1  in  5  decode rs1 index for hazard lookup.
- chk_rs2  in  5  decode rs2 index for hazard lookup.
- hit1  out  1  a pending write targets chk_rs1.
- hit2  out  1  a pending write targets chk_rs2.
- fwd1  out  DW  youngest pending data for chk_rs1.
- fwd2  out  DW  youngest pending data for chk_rs2.
- empty  out  1  queue and output register both idle.

Behaviour:
- Reset (async, rst_n low):
  - rd/wr pointers and count cleared to 0.
  - rf_wr=0, rf_rd=0, rf_wd=0.
  - Queue entry valid bits cleared; data contents are don't-care.
  - Reset mid-operation discards all pending writes; no rf_wr pulse is issued after reset asserts.
- Ready:
  - Combinational from the registered count only; never dependent on the producer's own valid.
  - free = DEPTH - count.
  - mem_ready = (free >= 1).
  - alu_ready = (free >= 2) or (free == 1 and not mem_valid).
- Push:
  - A handshake completes when valid and ready are both high at a rising edge.
  - When both producers complete in the same cycle, the mem entry is enqueued first (older), then the alu entry.
  - A request with rd == 0 completes its handshake but is dropped, not enqueued.
- Pop:
  - Every edge with count > 0 pops the head into the output registers: rf_wr=1, rf_rd=head.rd, rf_wd=head.data.
  - Otherwise rf_wr=0; rf_rd and rf_wd hold their last values.
  - Push and pop in the same cycle: count = count + pushes - 1.
  - When full, a same-cycle pop does not enable a push; ready reflects the pre-edge count.
- Latency:
  - Request accepted at edge N into an empty queue → popped at edge N+1 (rf_wr high during N+1..N+2) → register file written at edge N+2.
  - Sustained throughput is one write per cycle.
- Pointers:
  - Wrap modulo DEPTH.
  - count ranges 0..DEPTH and never overflows or underflows.
- Lookup (combinational):
  - Searches all valid queue entries plus the output register when rf_wr=1 (pending, not yet committed).
  - The youngest match wins; the output register is the oldest.
  - chk_rsX == 0 never hits.
  - No match → hitX=0, fwdX=0.
- empty = (count == 0) and not rf_wr.

Optional Feature:
- Macro: WBQ_FWD_EN.
- Defined: fwd1/fwd2 carry the youngest matching data as specified above.
- Undefined:
  - fwd1/fwd2 are tied to 0 and the data-match mux is not built.
  - hit1/hit2 remain functional; the core must stall on a hit.

Test Plan:
- Single write: reset, alu_valid=1, alu_rd=5, alu_data=0x12345678 for one cycle → rf_wr=1 with rf_rd=5, rf_wd=0x12345678 exactly one cycle after acceptance; empty=1 afterwards.
- Dual push order: both valid in one cycle, mem_rd=3/0xAAAA0000 and alu_rd=3/0x0000BBBB → two consecutive writes to rd 3, mem first, then alu; final lookup chk_rs1=3 before drain gives fwd1=0x0000BBBB.
- Backpressure, fill path:
  - Hold rf stalls impossible, so fill via 3 dual pushes with DEPTH=4.
  - alu_ready drops when free==1 with mem_valid=1.
  - count never exceeds 4.
  - No entry is lost or duplicated across 6 requests.
- x0 drop: mem_valid=1, mem_rd=0, mem_data=0xFFFFFFFF → mem_ready=1, no rf_wr pulse; chk_rs1=0 gives hit1=0.
- Reset mid-operation: queue 3 entries, assert rst_n=0 for one cycle → rf_wr=0 immediately; no further writes; empty=1; alu_ready=mem_ready=1.
- WBQ_FWD_EN undefined: repeat the dual-push test → hit1=1, fwd1=0.
